// File: rtl/seg7_bcd_capture.sv
// Snoops a muxed active-low 7-seg bus, debounces each digit and rebuilds a BCD frame.
// Latency: capture STABLE_CYC edges after a digit settles, frame_valid one edge later; no backpressure.
module seg7_bcd_capture #(
  parameter int DIGITS     = 4,
  parameter int STABLE_CYC = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  a,
  input  logic                  b,
  input  logic                  c,
  input  logic                  d,
  input  logic                  e,
  input  logic                  f,
  input  logic                  g,
  input  logic [DIGITS-1:0]     an,
  output logic [4*DIGITS-1:0]   bcd,
  output logic                  frame_valid,
  output logic [DIGITS-1:0]     digit_err
);

  localparam logic [3:0] STABLE = 4'(STABLE_CYC);

  logic [6:0]          pat_in;
  logic [6:0]          pat_q;
  logic [DIGITS-1:0]   an_q;
  logic [3:0]          cnt_q;
  logic                captured_q;
  logic [DIGITS-1:0]   mask_q;
  logic [DIGITS-1:0]   err_sh_q;
  logic [4*DIGITS-1:0] shadow_q;
  logic                pend_q;

  logic [DIGITS-1:0]   sel_oh;
  logic                sel_ok;
  logic                same;
  logic                cap;
  logic [3:0]          cnt_d;
  logic                captured_d;
  logic [DIGITS-1:0]   cap_oh;
  logic [DIGITS-1:0]   mask_base;
  logic [DIGITS-1:0]   mask_new;
  logic [4:0]          dec;

  assign pat_in = {a, b, c, d, e, f, g};

  // {invalid, bcd}; blank is a legal pattern, not an error
  function automatic logic [4:0] decode(input logic [6:0] p);
    case (p)
      7'b0000001: decode = 5'h00;
      7'b1001111: decode = 5'h01;
      7'b0010010: decode = 5'h02;
      7'b0000110: decode = 5'h03;
      7'b1001100: decode = 5'h04;
      7'b0100100: decode = 5'h05;
      7'b0100000: decode = 5'h06;
      7'b1100000: decode = 5'h06;
      7'b0001111: decode = 5'h07;
      7'b0000000: decode = 5'h08;
      7'b0000100: decode = 5'h09;
      7'b0001100: decode = 5'h09;
      7'b1111111: decode = 5'h0F;
      default:    decode = 5'h1E;
    endcase
  endfunction

  // Count tracks runs of the held sample; the incoming sample extends or restarts it.
  always_comb begin
    sel_oh     = ~an;
    sel_ok     = (sel_oh != '0) && ((sel_oh & (sel_oh - DIGITS'(1))) == '0);
    same       = ({pat_in, an} == {pat_q, an_q});
    cnt_d      = '0;
    captured_d = 1'b0;
    cap        = 1'b0;
    if (sel_ok) begin
      if (!same) begin
        cnt_d = 4'd1;
      end else begin
        cnt_d      = (cnt_q < STABLE) ? cnt_q + 4'd1 : cnt_q;
        cap        = (cnt_d == STABLE) && !captured_q;
        captured_d = captured_q | cap;
      end
    end
    cap_oh    = cap ? sel_oh : '0;
    dec       = decode(pat_q);
    mask_base = pend_q ? '0 : mask_q;
    mask_new  = mask_base | cap_oh;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pat_q       <= 7'h7F;
      an_q        <= '1;
      cnt_q       <= '0;
      captured_q  <= 1'b0;
      mask_q      <= '0;
      err_sh_q    <= '0;
      shadow_q    <= '1;
      pend_q      <= 1'b0;
      bcd         <= '1;
      frame_valid <= 1'b0;
      digit_err   <= '0;
    end else begin
      pat_q       <= pat_in;
      an_q        <= an;
      cnt_q       <= cnt_d;
      captured_q  <= captured_d;
      mask_q      <= mask_new;
      pend_q      <= cap && (&mask_new);
      frame_valid <= pend_q;
      if (pend_q) begin
        bcd       <= shadow_q;
        digit_err <= err_sh_q;
      end
      for (int k = 0; k < DIGITS; k++) begin
        if (cap_oh[k]) begin
          shadow_q[4*k +: 4] <= dec[3:0];
          err_sh_q[k]        <= dec[4];
        end
      end
    end
  end

endmodule

// File: tb/tb_seg7_bcd_capture.sv
// Bench for seg7_bcd_capture: scan table with frame scoreboard, plus reset and long-dwell sequences.
module tb_seg7_bcd_capture;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [6:0]  pat;
  logic [3:0]  an;
  logic        an1;
  logic [15:0] bcd;
  logic        fv;
  logic [3:0]  derr;
  logic [3:0]  bcd1;
  logic        fv1;
  logic        derr1;

  always #5 clk = ~clk;

  seg7_bcd_capture #(.DIGITS(4), .STABLE_CYC(3)) dut (
    .clk(clk), .rst_n(rst_n),
    .a(pat[6]), .b(pat[5]), .c(pat[4]), .d(pat[3]), .e(pat[2]), .f(pat[1]), .g(pat[0]),
    .an(an), .bcd(bcd), .frame_valid(fv), .digit_err(derr)
  );

  seg7_bcd_capture #(.DIGITS(1), .STABLE_CYC(3)) dut1 (
    .clk(clk), .rst_n(rst_n),
    .a(pat[6]), .b(pat[5]), .c(pat[4]), .d(pat[3]), .e(pat[2]), .f(pat[1]), .g(pat[0]),
    .an(an1), .bcd(bcd1), .frame_valid(fv1), .digit_err(derr1)
  );

  typedef struct {
    logic [3:0]  an;
    logic [6:0]  pat;
    int          cyc;
    bit          push;
    logic [15:0] ebcd;
    logic [3:0]  eerr;
  } vec_t;

  typedef struct {
    logic [15:0] ebcd;
    logic [3:0]  eerr;
  } exp_t;

  vec_t vt[$];
  exp_t expq[$];
  int   n_vec = 0;
  int   n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic add(input logic [3:0] a_n, input logic [6:0] p, input int cyc,
                     input bit push, input logic [15:0] eb, input logic [3:0] ee);
    vec_t v;
    v.an = a_n; v.pat = p; v.cyc = cyc; v.push = push; v.ebcd = eb; v.eerr = ee;
    vt.push_back(v);
  endtask

  task automatic dwell(input logic [3:0] a_n, input logic [6:0] p, input int cyc);
    @(negedge clk);
    an  = a_n;
    pat = p;
    repeat (cyc - 1) @(negedge clk);
  endtask

  // Scoreboard: every frame_valid pulse must match the oldest pending expectation
  always @(negedge clk) begin
    if (rst_n === 1'b1 && fv === 1'b1) begin
      if (expq.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_frame_valid: bcd=%h digit_err=%b, no frame pending", bcd, derr);
      end else begin
        exp_t x;
        x = expq.pop_front();
        chk("frame_bcd", 32'(bcd), 32'(x.ebcd));
        chk("frame_digit_err", 32'(derr), 32'(x.eerr));
      end
    end
  end

  initial begin
    int pulses;
    rst_n = 1'b0;
    pat   = 7'h7F;
    an    = 4'hF;
    an1   = 1'b1;

    // frame "2024": digits 0..3 = 2,0,2,4
    add(4'b1110, 7'b0010010, 8, 0, 16'h0, 4'h0);
    add(4'b1101, 7'b0000001, 8, 0, 16'h0, 4'h0);
    add(4'b1011, 7'b0010010, 8, 0, 16'h0, 4'h0);
    add(4'b0111, 7'b1001100, 8, 1, 16'h4202, 4'h0);
    // short 2-cycle dwell on digit0 showing 8 must be rejected
    add(4'b1110, 7'b1001111, 8, 0, 16'h0, 4'h0);
    add(4'b1101, 7'b0100100, 8, 0, 16'h0, 4'h0);
    add(4'b1110, 7'b0000000, 2, 0, 16'h0, 4'h0);
    add(4'b1011, 7'b1100000, 8, 0, 16'h0, 4'h0);
    add(4'b0111, 7'b0001100, 8, 1, 16'h9651, 4'h0);
    // invalid digit1, blank digit3, bad selects in between
    add(4'b1110, 7'b0000110, 8, 0, 16'h0, 4'h0);
    add(4'b1101, 7'b1110110, 8, 0, 16'h0, 4'h0);
    add(4'b1100, 7'b0000000, 20, 0, 16'h0, 4'h0);
    add(4'b1111, 7'b0000000, 20, 0, 16'h0, 4'h0);
    add(4'b1011, 7'b0001111, 8, 0, 16'h0, 4'h0);
    add(4'b0111, 7'b1111111, 8, 1, 16'hF7E3, 4'b0010);
    // permuted order with a repeat of digit1 overwriting 9 with 3
    add(4'b0111, 7'b0000000, 8, 0, 16'h0, 4'h0);
    add(4'b1101, 7'b0000100, 8, 0, 16'h0, 4'h0);
    add(4'b1110, 7'b0100000, 8, 0, 16'h0, 4'h0);
    add(4'b1101, 7'b0000110, 8, 0, 16'h0, 4'h0);
    add(4'b1011, 7'b0000001, 8, 1, 16'h8036, 4'h0);

    repeat (3) @(negedge clk);
    chk("reset_bcd", 32'(bcd), 32'hFFFF);
    chk("reset_frame_valid", 32'(fv), 32'h0);
    chk("reset_digit_err", 32'(derr), 32'h0);
    chk("reset_bcd_d1", 32'(bcd1), 32'hF);
    @(negedge clk);
    rst_n = 1'b1;

    foreach (vt[i]) begin
      @(negedge clk);
      an  = vt[i].an;
      pat = vt[i].pat;
      if (vt[i].push) expq.push_back('{vt[i].ebcd, vt[i].eerr});
      repeat (vt[i].cyc - 1) @(negedge clk);
    end
    @(negedge clk);
    an = 4'hF;
    repeat (10) @(negedge clk);
    chk("frames_outstanding", 32'(expq.size()), 32'h0);
    chk("bcd_hold", 32'(bcd), 32'h8036);

    // reset mid-scan: outputs clear at once, partial frame is discarded
    dwell(4'b1110, 7'b0000001, 8);
    dwell(4'b1101, 7'b1001111, 5);
    rst_n = 1'b0;
    #1;
    chk("midreset_bcd", 32'(bcd), 32'hFFFF);
    chk("midreset_frame_valid", 32'(fv), 32'h0);
    chk("midreset_digit_err", 32'(derr), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    dwell(4'b1011, 7'b0001111, 8);
    dwell(4'b0111, 7'b0000000, 8);
    @(negedge clk);
    an = 4'hF;
    repeat (10) @(negedge clk);
    chk("partial_frame_bcd", 32'(bcd), 32'hFFFF);

    // single-digit long dwell: pulse after the 4th edge, exactly once
    @(negedge clk);
    an1 = 1'b0;
    pat = 7'b0000110;
    for (int i = 1; i <= 3; i++) begin
      @(negedge clk);
      chk($sformatf("d1_early_edge%0d", i), 32'(fv1), 32'h0);
    end
    @(negedge clk);
    chk("d1_pulse_edge4", 32'(fv1), 32'h1);
    chk("d1_bcd", 32'(bcd1), 32'h3);
    chk("d1_digit_err", 32'(derr1), 32'h0);
    pulses = 0;
    for (int i = 5; i <= 50; i++) begin
      @(negedge clk);
      if (fv1 === 1'b1) pulses++;
    end
    chk("d1_extra_pulses", 32'(pulses), 32'h0);
    an1 = 1'b1;
    repeat (2) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
